// File: rtl/plab4_net_router_input_ctrl_arbiter_tdm.sv
// ============================================================================
// plab4_net_router_input_ctrl_arbiter_tdm
//
// Time-division-multiplexed input controller for a ring router input port
// shared by several security domains. Ownership of the input rotates through
// the domains in fixed-length time slots. The rotation is driven only by free
// running counters, so no domain can influence when another domain is served.
// Only the domain that owns the current slot may raise output-port requests
// or receive a ready.
//
// Parameters
//   p_router_id     id of this router on the ring
//   p_num_routers   routers on the ring (sets the destination field width)
//   p_num_domains   security domains sharing this input (1..8)
//   p_slot_cycles   cycles per domain time slot (2..256)
//   p_default_reqs  request vector used for non-local destinations
//
// Ports
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   dest        per-domain head-flit destination, domain d in slice d
//   in_val      per-domain valid
//   in_rdy      per-domain ready (only the slot owner can see a 1)
//   reqs        {west, terminal, east} requests of the slot owner
//   grants      grants from the switch allocator, same encoding as reqs
//   cur_domain  domain owning the current slot
//   slot_start  high in the first cycle of every slot
//
// Configuration macro
//   PLAB4_NET_TDM_DEAD_CYCLE_EN  when defined, the last cycle of every slot
//                                is a dead cycle: reqs and in_rdy are forced
//                                to zero so no transfer crosses a boundary.
// ============================================================================
module plab4_net_router_input_ctrl_arbiter_tdm #(
    parameter int         p_router_id    = 0,
    parameter int         p_num_routers  = 8,
    parameter int         p_num_domains  = 2,
    parameter int         p_slot_cycles  = 4,
    parameter logic [2:0] p_default_reqs = 3'b001,
    localparam int        c_dest_nbits   = $clog2(p_num_routers),
    localparam int        c_dom_nbits    = (p_num_domains > 1) ? $clog2(p_num_domains) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [p_num_domains*c_dest_nbits-1:0] dest,
    input  logic [p_num_domains-1:0]              in_val,
    output logic [p_num_domains-1:0]              in_rdy,
    output logic [2:0]                            reqs,
    input  logic [2:0]                            grants,
    output logic [c_dom_nbits-1:0]                cur_domain,
    output logic                                  slot_start
);

    localparam int                      c_slot_nbits = $clog2(p_slot_cycles);
    localparam logic [c_slot_nbits-1:0] c_slot_last  = c_slot_nbits'(p_slot_cycles - 1);
    localparam logic [c_dom_nbits-1:0]  c_dom_last   = c_dom_nbits'(p_num_domains - 1);
    localparam logic [c_dest_nbits-1:0] c_router_id  = c_dest_nbits'(p_router_id);

    // ------------------------------------------------------------------------
    // Slot / domain counters
    // ------------------------------------------------------------------------
    logic [c_slot_nbits-1:0] slot_cnt_reg;
    logic [c_slot_nbits-1:0] slot_cnt_next;
    logic [c_dom_nbits-1:0]  dom_cnt_reg;
    logic [c_dom_nbits-1:0]  dom_cnt_next;
    logic                    slot_last;

    assign slot_last = (slot_cnt_reg == c_slot_last);

    always_comb begin
        slot_cnt_next = slot_cnt_reg + c_slot_nbits'(1);
        dom_cnt_next  = dom_cnt_reg;
        if (slot_last) begin
            slot_cnt_next = '0;
            // With a single domain c_dom_last is 0, so the domain stays at 0.
            dom_cnt_next  = (dom_cnt_reg == c_dom_last) ? '0
                                                        : dom_cnt_reg + c_dom_nbits'(1);
        end
    end

    // Reset acts immediately: a slot in progress is abandoned and the
    // schedule restarts at domain 0, cycle 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt_reg <= '0;
            dom_cnt_reg  <= '0;
        end else begin
            slot_cnt_reg <= slot_cnt_next;
            dom_cnt_reg  <= dom_cnt_next;
        end
    end

    assign cur_domain = dom_cnt_reg;
    assign slot_start = (slot_cnt_reg == '0);

    // ------------------------------------------------------------------------
    // Dead-cycle option
    // ------------------------------------------------------------------------
    logic slot_quiet;

`ifdef PLAB4_NET_TDM_DEAD_CYCLE_EN
    assign slot_quiet = slot_last;
`else
    assign slot_quiet = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Per-domain route computation and ready fan-out
    // ------------------------------------------------------------------------
    logic [2:0] dom_reqs [p_num_domains];
    logic [2:0] owner_req;
    logic       xfer_ok;

    generate
        for (genvar gi = 0; gi < p_num_domains; gi++) begin : g_dom
            logic [c_dest_nbits-1:0] dom_dest;

            assign dom_dest     = dest[gi*c_dest_nbits +: c_dest_nbits];
            assign dom_reqs[gi] = !in_val[gi]               ? 3'b000 :
                                  (dom_dest == c_router_id) ? 3'b010 :
                                                              p_default_reqs;

            // Only the slot owner can ever see ready; everyone else is
            // blocked regardless of what the allocator does.
            assign in_rdy[gi] = (dom_cnt_reg == c_dom_nbits'(gi)) && xfer_ok;
        end
    endgenerate

    // Select the owner's request. Counter values beyond p_num_domains-1 are
    // unreachable, so the zero default never shows in practice.
    always_comb begin
        owner_req = 3'b000;
        for (int d = 0; d < p_num_domains; d++) begin
            if (dom_cnt_reg == c_dom_nbits'(d)) begin
                owner_req = dom_reqs[d];
            end
        end
    end

    assign reqs = slot_quiet ? 3'b000 : owner_req;

    // Grants are only meaningful where they overlap our own request; stray
    // grant bits (or grants while idle) never produce a ready.
    assign xfer_ok = |(reqs & grants);

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_arbiter_tdm.sv
// ============================================================================
// Testbench for plab4_net_router_input_ctrl_arbiter_tdm.
// DUT a: 2 domains, 4-cycle slots, router id 2, 8 routers.
// DUT b: 1 domain, 4-cycle slots, router id 2, fixed traffic to dest 7.
// Expected values come from a constant vector table plus hand sequences;
// each driven vector pushes its expectation, popped when outputs are sampled.
// ============================================================================
module tb_plab4_net_router_input_ctrl_arbiter_tdm;

`ifdef PLAB4_NET_TDM_DEAD_CYCLE_EN
    localparam bit c_dead = 1'b1;
`else
    localparam bit c_dead = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;

    // DUT a
    logic [5:0] dest;
    logic [1:0] in_val;
    logic [1:0] in_rdy;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic [0:0] cur_domain;
    logic       slot_start;

    // DUT b
    logic [2:0] b_dest;
    logic [0:0] b_in_val;
    logic [0:0] b_in_rdy;
    logic [2:0] b_reqs;
    logic [2:0] b_grants;
    logic [0:0] b_cur_domain;
    logic       b_slot_start;

    always #5 clk = ~clk;

    plab4_net_router_input_ctrl_arbiter_tdm #(
        .p_router_id    (2),
        .p_num_routers  (8),
        .p_num_domains  (2),
        .p_slot_cycles  (4),
        .p_default_reqs (3'b001)
    ) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .dest       (dest),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .reqs       (reqs),
        .grants     (grants),
        .cur_domain (cur_domain),
        .slot_start (slot_start)
    );

    plab4_net_router_input_ctrl_arbiter_tdm #(
        .p_router_id    (2),
        .p_num_routers  (8),
        .p_num_domains  (1),
        .p_slot_cycles  (4),
        .p_default_reqs (3'b001)
    ) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .dest       (b_dest),
        .in_val     (b_in_val),
        .in_rdy     (b_in_rdy),
        .reqs       (b_reqs),
        .grants     (b_grants),
        .cur_domain (b_cur_domain),
        .slot_start (b_slot_start)
    );

    typedef struct {
        logic [1:0] val;
        logic [2:0] d0;
        logic [2:0] d1;
        logic [2:0] gnt;
        logic [2:0] e_reqs;
        logic [1:0] e_rdy;
        logic       e_dom;
        logic       e_ss;
    } vec_t;

    typedef struct {
        string      tag;
        logic [2:0] reqs;
        logic [1:0] rdy;
        logic       dom;
        logic       ss;
        logic       chk_b;
        logic [2:0] b_reqs;
        logic       b_rdy;
        logic       b_ss;
    } exp_t;

    vec_t vecs [25];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [1:0] val, input logic [2:0] d0,
                           input logic [2:0] d1, input logic [2:0] gnt,
                           input logic [2:0] e_reqs, input logic [1:0] e_rdy,
                           input logic e_dom, input logic e_ss);
        vecs[i] = '{val, d0, d1, gnt, e_reqs, e_rdy, e_dom, e_ss};
    endtask

    function automatic exp_t mk(input string tag, input logic [2:0] r, input logic [1:0] rdy,
                                input logic dom, input logic ss);
        exp_t e;
        e.tag = tag; e.reqs = r; e.rdy = rdy; e.dom = dom; e.ss = ss;
        e.chk_b = 1'b0; e.b_reqs = 3'b000; e.b_rdy = 1'b0; e.b_ss = 1'b0;
        return e;
    endfunction

    // Pop the oldest expectation and compare against the sampled outputs.
    task automatic check_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        $display("txn %s: dom=%0d ss=%0d reqs=%b in_rdy=%b | b: reqs=%b in_rdy=%b ss=%0d",
                 e.tag, cur_domain, slot_start, reqs, in_rdy, b_reqs, b_in_rdy, b_slot_start);
        chk({e.tag, " cur_domain"}, int'(cur_domain), int'(e.dom));
        chk({e.tag, " slot_start"}, int'(slot_start), int'(e.ss));
        chk({e.tag, " reqs"},       int'(reqs),       int'(e.reqs));
        chk({e.tag, " in_rdy"},     int'(in_rdy),     int'(e.rdy));
        if (e.chk_b) begin
            chk({e.tag, " b_cur_domain"}, int'(b_cur_domain), 0);
            chk({e.tag, " b_slot_start"}, int'(b_slot_start), int'(e.b_ss));
            chk({e.tag, " b_reqs"},       int'(b_reqs),       int'(e.b_reqs));
            chk({e.tag, " b_in_rdy"},     int'(b_in_rdy),     int'(e.b_rdy));
        end
    endtask

    // Drive one cycle's inputs (called just after a rising edge), check at the
    // following falling edge, and return just after the next rising edge.
    task automatic apply(input logic [1:0] val, input logic [2:0] d0, input logic [2:0] d1,
                         input logic [2:0] gnt, input exp_t e);
        in_val = val;
        dest   = {d1, d0};
        grants = gnt;
        sb.push_back(e);
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;

        // val   d0    d1    gnt     reqs    rdy    dom ss
        set_vec( 0, 2'b00, 3'd0, 3'd0, 3'b000, 3'b000, 2'b00, 0, 1);
        set_vec( 1, 2'b00, 3'd0, 3'd0, 3'b000, 3'b000, 2'b00, 0, 0);
        set_vec( 2, 2'b00, 3'd0, 3'd0, 3'b000, 3'b000, 2'b00, 0, 0);
        set_vec( 3, 2'b00, 3'd0, 3'd0, 3'b000, 3'b000, 2'b00, 0, 0);
        set_vec( 4, 2'b00, 3'd0, 3'd0, 3'b000, 3'b000, 2'b00, 1, 1);
        set_vec( 5, 2'b00, 3'd0, 3'd0, 3'b000, 3'b000, 2'b00, 1, 0);
        set_vec( 6, 2'b00, 3'd0, 3'd0, 3'b000, 3'b000, 2'b00, 1, 0);
        set_vec( 7, 2'b00, 3'd0, 3'd0, 3'b000, 3'b000, 2'b00, 1, 0);
        set_vec( 8, 2'b01, 3'd2, 3'd0, 3'b010, 3'b010, 2'b01, 0, 1);
        set_vec( 9, 2'b01, 3'd2, 3'd0, 3'b000, 3'b010, 2'b00, 0, 0);
        set_vec(10, 2'b10, 3'd0, 3'd5, 3'b001, 3'b000, 2'b00, 0, 0);
        set_vec(11, 2'b01, 3'd2, 3'd0, 3'b010, 3'b010, 2'b01, 0, 0);
        set_vec(12, 2'b10, 3'd0, 3'd5, 3'b001, 3'b001, 2'b10, 1, 1);
        set_vec(13, 2'b10, 3'd0, 3'd5, 3'b010, 3'b001, 2'b00, 1, 0);
        set_vec(14, 2'b10, 3'd0, 3'd5, 3'b000, 3'b001, 2'b00, 1, 0);
        set_vec(15, 2'b10, 3'd0, 3'd5, 3'b000, 3'b001, 2'b00, 1, 0);
        set_vec(16, 2'b11, 3'd5, 3'd2, 3'b111, 3'b001, 2'b01, 0, 1);
        set_vec(17, 2'b11, 3'd2, 3'd2, 3'b101, 3'b010, 2'b00, 0, 0);
        set_vec(18, 2'b10, 3'd0, 3'd2, 3'b111, 3'b000, 2'b00, 0, 0);
        set_vec(19, 2'b11, 3'd0, 3'd2, 3'b001, 3'b001, 2'b01, 0, 0);
        set_vec(20, 2'b11, 3'd2, 3'd2, 3'b010, 3'b010, 2'b10, 1, 1);
        set_vec(21, 2'b01, 3'd2, 3'd0, 3'b010, 3'b000, 2'b00, 1, 0);
        set_vec(22, 2'b10, 3'd0, 3'd7, 3'b001, 3'b001, 2'b10, 1, 0);
        set_vec(23, 2'b10, 3'd0, 3'd7, 3'b001, 3'b001, 2'b10, 1, 0);
        set_vec(24, 2'b10, 3'd0, 3'd7, 3'b001, 3'b000, 2'b00, 0, 1);

        b_dest   = 3'd7;
        b_in_val = 1'b1;
        b_grants = 3'b111;

        // Reset state, held across a clock edge: counters must not move.
        reset_n = 1'b0;
        in_val  = 2'b01;
        dest    = {3'd0, 3'd2};
        grants  = 3'b010;
        for (int r = 0; r < 2; r++) begin
            e = mk($sformatf("reset%0d", r), 3'b010, 2'b01, 1'b0, 1'b1);
            e.chk_b = 1'b1; e.b_reqs = 3'b001; e.b_rdy = 1'b1; e.b_ss = 1'b1;
            sb.push_back(e);
            @(negedge clk);
            check_outputs();
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Table-driven cycles; entry i sits at cycle i after reset release.
        for (int i = 0; i < 25; i++) begin
            bit quiet;
            quiet = c_dead && ((i % 4) == 3);
            e = mk($sformatf("vec%0d", i), quiet ? 3'b000 : vecs[i].e_reqs,
                   quiet ? 2'b00 : vecs[i].e_rdy, vecs[i].e_dom, vecs[i].e_ss);
            e.chk_b  = 1'b1;
            e.b_reqs = quiet ? 3'b000 : 3'b001;
            e.b_rdy  = !quiet;
            e.b_ss   = ((i % 4) == 0);
            apply(vecs[i].val, vecs[i].d0, vecs[i].d1, vecs[i].gnt, e);
        end

        // Walk to domain 1, cycle 2, then pull reset mid-slot.
        apply(2'b00, 3'd0, 3'd0, 3'b000, mk("walk25", 3'b000, 2'b00, 1'b0, 1'b0));
        apply(2'b00, 3'd0, 3'd0, 3'b000, mk("walk26", 3'b000, 2'b00, 1'b0, 1'b0));
        apply(2'b00, 3'd0, 3'd0, 3'b000, mk("walk27", 3'b000, 2'b00, 1'b0, 1'b0));
        apply(2'b00, 3'd0, 3'd0, 3'b000, mk("walk28", 3'b000, 2'b00, 1'b1, 1'b1));
        apply(2'b00, 3'd0, 3'd0, 3'b000, mk("walk29", 3'b000, 2'b00, 1'b1, 1'b0));
        in_val = 2'b10;
        dest   = {3'd5, 3'd0};
        grants = 3'b001;
        sb.push_back(mk("d1c2", 3'b001, 2'b10, 1'b1, 1'b0));
        @(negedge clk);
        check_outputs();
        reset_n = 1'b0;
        #1;
        sb.push_back(mk("async_rst", 3'b000, 2'b00, 1'b0, 1'b1));
        check_outputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply(2'b10, 3'd0, 3'd5, 3'b001, mk("post_rst0", 3'b000, 2'b00, 1'b0, 1'b1));
        apply(2'b10, 3'd0, 3'd5, 3'b001, mk("post_rst1", 3'b000, 2'b00, 1'b0, 1'b0));

        if (sb.size() != 0) begin
            chk("scoreboard_drain", sb.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plab4_net_router_input_ctrl_arbiter_tdm.md
PLAB4_NET_ROUTER_INPUT_CTRL_ARBITER_TDM -- requirements
Module: plab4_net_router_input_ctrl_arbiter_tdm

Interface
REQ-001 SHALL have parameter p_router_id, default 0: id of this router on the ring.
REQ-002 SHALL have parameter p_num_routers, default 8: routers on the ring; c_dest_nbits = $clog2(p_num_routers).
REQ-003 SHALL have parameter p_num_domains, default 2: security domains sharing the input, range 1..8; c_dom_nbits = max(1, $clog2(p_num_domains)).
REQ-004 SHALL have parameter p_slot_cycles, default 4: cycles per domain time slot, range 2..256.
REQ-005 SHALL have parameter p_default_reqs, default 3'b001: request vector for non-local destinations.
REQ-006 SHALL have ports clk (input, 1): sole clock, rising edge; one clock domain.
REQ-007 SHALL have port reset_n (input, 1): asynchronous, active-low reset.
REQ-008 SHALL have port dest (input, p_num_domains*c_dest_nbits): per-domain head-flit destination; domain d at slice d.
REQ-009 SHALL have port in_val (input, p_num_domains): per-domain valid.
REQ-010 SHALL have port in_rdy (output, p_num_domains): per-domain ready.
REQ-011 SHALL have port reqs (output, 3): {west, terminal, east} output-port requests of the slot owner.
REQ-012 SHALL have port grants (input, 3): grants from the switch allocator, same encoding.
REQ-013 SHALL have port cur_domain (output, c_dom_nbits): domain owning the current slot.
REQ-014 SHALL have port slot_start (output, 1): high in the first cycle of every slot.

Function
REQ-015 SHALL keep a slot-cycle counter (0..p_slot_cycles-1) and a domain counter (0..p_num_domains-1); the cycle counter increments every cycle and wraps to 0; on wrap, the domain counter increments and wraps from p_num_domains-1 to 0.
REQ-016 SHALL drive cur_domain from the domain counter register, independent of in_val, dest or grants (no data-dependent switching).
REQ-017 SHALL assert slot_start when the cycle counter equals 0.
REQ-018 SHALL compute the owner request: 3'b000 if in_val[owner]=0; 3'b010 if dest[owner]==p_router_id; else p_default_reqs.
REQ-019 SHALL drive reqs with the owner request combinationally (zero latency); non-owner domains contribute nothing.
REQ-020 SHALL assert in_rdy[d] only when d==cur_domain and (reqs & grants)!=0; all other in_rdy bits 0.
REQ-021 SHALL ignore grants when reqs==0, and grant bits outside reqs SHALL NOT complete a transfer.
REQ-022 SHALL complete a transfer on a cycle with in_val[d] & in_rdy[d]; a waiting owner holds its request across cycles with no internal buffering.
REQ-023 SHALL, with p_num_domains=1, hold cur_domain at 0 and still run the slot counter and slot_start.
REQ-024 SHALL treat a request pending at slot end as withdrawn; the next owner's request appears in the first cycle of the new slot.

Reset
REQ-025 SHALL, while reset_n=0, clear both counters immediately: cur_domain=0, slot_start=1, reqs=owner request of domain 0, in_rdy per REQ-020.
REQ-026 SHALL, on reset assertion mid-slot, abandon the current slot and restart at domain 0, cycle 0 after release.

Configuration
REQ-027 SHALL support macro PLAB4_NET_TDM_DEAD_CYCLE_EN.
REQ-028 SHALL, when PLAB4_NET_TDM_DEAD_CYCLE_EN is defined, force reqs=0 and in_rdy=0 in the last cycle of every slot (cycle p_slot_cycles-1), so no transfer crosses a slot boundary.
REQ-029 SHALL, when the macro is undefined, allow requests in every slot cycle.

Verification
(Parameters: p_num_domains=2, p_slot_cycles=4, p_router_id=2, p_num_routers=8.)
REQ-030 Reset release, in_val=0 -> cur_domain sequence 0,0,0,0,1,1,1,1,0; slot_start high on cycles 0,4,8.
REQ-031 Domain 0 in_val=1, dest=2, grants=3'b010 in slot 0 -> reqs=3'b010, in_rdy=2'b01; macro defined: cycle 3 reqs=0, in_rdy=0.
REQ-032 Domain 1 in_val=1, dest=5, in slot 0 -> reqs=0, in_rdy=0; in slot 1 -> reqs=3'b001, in_rdy=2'b10 when grants=3'b001.
REQ-033 Owner reqs=3'b001, grants=3'b010 -> in_rdy=0; grants=3'b000 for 2 cycles -> reqs stays 3'b001.
REQ-034 reset_n low at domain 1 cycle 2, then released -> cur_domain=0, slot_start=1 in the first cycle after release.
REQ-035 p_num_domains=1 build, in_val=1, dest=7, grants=3'b111 -> reqs=3'b001, in_rdy=1 every cycle (macro undefined).
